// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state and owner encodings for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, XFER_CPU = 2'd1, XFER_DMA = 2'd2} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational 2-way pick between eligible CPU and DMA requests
// Ports: cpu_elig/dma_elig eligible requests, last_owner previous grant, starve DMA wait bound hit
//        -> winner granted owner, valid some request eligible
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic   cpu_elig,
    input  logic   dma_elig,
    input  owner_t last_owner,
    input  logic   starve,
    output owner_t winner,
    output logic   valid
);
    always_comb begin
        valid  = cpu_elig | dma_elig;
        winner = owner_t'((cpu_elig & dma_elig)
               ? ((PRIO_MODE == 0) ? (last_owner == OWN_CPU) : starve)
               : dma_elig);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and a DMA/debug requester
// Ports: clk, reset (async, active-high); cpu_*/dma_* req/we/addr/wdata in, rdata/ack out;
//        mem_we/mem_addr/mem_wdata to data_mem, mem_rdata combinational read data back.
// Macro DMEM_ARB_PERF_EN adds cpu_stall_cnt and dma_grant_cnt saturating counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int PRIO_MODE    = 0,
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       cpu_stall_cnt,
    output logic [31:0]       dma_grant_cnt,
`endif
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t              state, state_nx;
    owner_t              last_owner, winner;
    logic                valid, cpu_elig, dma_elig, starve;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [7:0]          wait_cnt;

    // the owner's req is still high during its ack cycle, so mask it there
    assign cpu_elig = cpu_req & (state != XFER_CPU);
    assign dma_elig = dma_req & (state != XFER_DMA);
    assign starve   = (PRIO_MODE == 1) && (wait_cnt == DMA_MAX_WAIT[7:0]);

    dmem_arb_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
        .cpu_elig  (cpu_elig),
        .dma_elig  (dma_elig),
        .last_owner(last_owner),
        .starve    (starve),
        .winner    (winner),
        .valid     (valid)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx  = valid ? ((winner == OWN_DMA) ? XFER_DMA : XFER_CPU) : IDLE;
        cpu_ack   = state == XFER_CPU;
        dma_ack   = state == XFER_DMA;
        mem_we    = (state != IDLE) & lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        cpu_rdata = cpu_ack ? mem_rdata : '0;
        dma_rdata = dma_ack ? mem_rdata : '0;
    end

    // last_owner resets to DMA so the CPU wins the first tie
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            last_owner <= OWN_DMA;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
        end else if (valid) begin
            last_owner <= winner;
            lat_we     <= (winner == OWN_DMA) ? dma_we : cpu_we;
            lat_addr   <= (winner == OWN_DMA) ? dma_addr : cpu_addr;
            lat_wdata  <= (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
            if (winner == OWN_DMA)
                wait_cnt <= '0;
            else if (PRIO_MODE == 1 && dma_elig)
                wait_cnt <= wait_cnt + 8'd1;
        end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cpu_stall_cnt <= '0;
            dma_grant_cnt <= '0;
        end else begin
            if (cpu_req & ~cpu_ack & ~&cpu_stall_cnt)
                cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
            if (valid & (winner == OWN_DMA) & ~&dma_grant_cnt)
                dma_grant_cnt <= dma_grant_cnt + 32'd1;
        end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter (round-robin and CPU-priority instances)
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] c0_rdata, d0_rdata, m0_addr, m0_wdata, m0_rdata;
    logic [31:0] c1_rdata, d1_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        c0_ack, d0_ack, m0_we, c1_ack, d1_ack, m1_we;
    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];
    int          checks = 0, errors = 0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall0, grant0, stall1, grant1;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(.PRIO_MODE(0)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(c0_rdata), .cpu_ack(c0_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(d0_rdata), .dma_ack(d0_ack),
`ifdef DMEM_ARB_PERF_EN
        .cpu_stall_cnt(stall0), .dma_grant_cnt(grant0),
`endif
        .mem_we(m0_we), .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
    );

    dmem_arbiter #(.PRIO_MODE(1), .DMA_MAX_WAIT(3)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(d1_rdata), .dma_ack(d1_ack),
`ifdef DMEM_ARB_PERF_EN
        .cpu_stall_cnt(stall1), .dma_grant_cnt(grant1),
`endif
        .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
    );

    // word-addressed memories covering byte addresses 0x000-0x3FF
    wire hit0 = m0_addr[31:10] == '0 && m0_addr[1:0] == 2'b00;
    wire hit1 = m1_addr[31:10] == '0 && m1_addr[1:0] == 2'b00;
    assign m0_rdata = hit0 ? mem0[m0_addr[9:2]] : '0;
    assign m1_rdata = hit1 ? mem1[m1_addr[9:2]] : '0;
    always @(posedge clk) begin
        if (m0_we && hit0) mem0[m0_addr[9:2]] <= m0_wdata;
        if (m1_we && hit1) mem1[m1_addr[9:2]] <= m1_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {cpu_req, cpu_we, dma_req, dma_we} = '0;
        {cpu_addr, cpu_wdata, dma_addr, dma_wdata} = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        do_reset();
        chk("rst_cpu_ack", {31'd0, c0_ack}, 32'd0);
        chk("rst_dma_ack", {31'd0, d0_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, m0_we}, 32'd0);
        chk("rst_mem_addr", m0_addr, 32'd0);
        chk("rst_mem_wdata", m0_wdata, 32'd0);
        chk("rst_cpu_rdata", c0_rdata, 32'd0);
        chk("rst_dma_rdata", d0_rdata, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("rst_stall", stall0, 32'd0);
        chk("rst_grant", grant0, 32'd0);
        chk("rst_stall1", stall1, 32'd0);
        chk("rst_grant1", grant1, 32'd0);
`endif

        // CPU read of 0x54
        mem0[8'h15] = 32'h1234;
        cpu_req = 1'b1; cpu_addr = 32'h54;
        tick();
        chk("t1_ack", {31'd0, c0_ack}, 32'd1);
        chk("t1_rdata", c0_rdata, 32'h1234);
        chk("t1_mem_we", {31'd0, m0_we}, 32'd0);
        chk("t1_mem_addr", m0_addr, 32'h54);
        cpu_req = 1'b0;
        tick();
        chk("t1_idle_ack", {31'd0, c0_ack}, 32'd0);

        // simultaneous writes, round-robin: CPU first after reset
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h54; cpu_wdata = 32'hA;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h58; dma_wdata = 32'hB;
        tick();
        chk("t2_cpu_ack", {31'd0, c0_ack}, 32'd1);
        chk("t2_dma_wait", {31'd0, d0_ack}, 32'd0);
        chk("t2_mem_we", {31'd0, m0_we}, 32'd1);
        chk("t2_dma_rdata0", d0_rdata, 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("t2_dma_ack", {31'd0, d0_ack}, 32'd1);
        chk("t2_cpu_done", {31'd0, c0_ack}, 32'd0);
        chk("t2_mem_addr", m0_addr, 32'h58);
        chk("t2_dma_rdata", d0_rdata, 32'd0);
        chk("t2_mem54", mem0[8'h15], 32'hA);
        dma_req = 1'b0;
        tick();
        chk("t2_mem58", mem0[8'h16], 32'hB);
        chk("t2_idle", {30'd0, c0_ack, d0_ack}, 32'd0);

        // single requester held: one access every two cycles
        do_reset();
        cpu_req = 1'b1; cpu_addr = 32'h58;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("t4_ack%0d", i), {31'd0, c0_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        cpu_req = 1'b0;

        // reset during a CPU write aborts it
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h54; cpu_wdata = 32'hDEAD;
        tick();
        chk("t5_we_before", {31'd0, m0_we}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_we_reset", {31'd0, m0_we}, 32'd0);
        chk("t5_ack_reset", {31'd0, c0_ack}, 32'd0);
        tick();
        chk("t5_mem_kept", mem0[8'h15], 32'hA);
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU priority with DMA_MAX_WAIT=3: DMA loses at edges 0,2,4 and wins at 6
        do_reset();
        mem1[8'h04] = 32'h1111;
        mem1[8'h08] = 32'h2222;
        cpu_req = 1'b1; cpu_addr = 32'h10; dma_addr = 32'h20;
        for (int i = 0; i < 7; i++) begin
            dma_req = (i % 2 == 0);
            tick();
            if (i == 0) chk("t3_cpu_rdata", c1_rdata, 32'h1111);
            if (i == 4) chk("t3_wait3", {24'd0, u1.wait_cnt}, 32'd3);
            chk($sformatf("t3_dma_ack%0d", i), {31'd0, d1_ack}, (i == 6) ? 32'd1 : 32'd0);
        end
        chk("t3_cpu_ack", {31'd0, c1_ack}, 32'd0);
        chk("t3_dma_rdata", d1_rdata, 32'h2222);
        chk("t3_wait0", {24'd0, u1.wait_cnt}, 32'd0);
        cpu_req = 1'b0; dma_req = 1'b0;

`ifdef DMEM_ARB_PERF_EN
        // both held: CPU stalls at edges 0,2,4,6, DMA granted at 1,3,5,7
        do_reset();
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t6_dma_ack", {31'd0, d0_ack}, 32'd1);
        chk("t6_stall", stall0, 32'd4);
        chk("t6_grant", grant0, 32'd4);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        tick();
        chk("t6_stall_hold", stall0, 32'd4);
        chk("t6_grant_hold", grant0, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
